// File: rtl/excess3_pkg.sv
// Shared constants and FSM state type for the BCD to Excess-3 sequencer.
package excess3_pkg;
    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] XS3_INVALID = 4'hF;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/excess3_seq_ctrl_if.sv
// Front (BCD word in) and back (Excess-3 word out) handshakes of excess3_seq_ctrl.
interface excess3_seq_ctrl_if #(parameter int NDIG = 4);
    import excess3_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [DIGIT_W*NDIG-1:0]   in_bcd;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIGIT_W*NDIG-1:0]   out_xs3;
    logic                      out_err;
    logic                      busy;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_xs3, out_err, busy
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_xs3, out_err, busy
    );
endinterface

// File: rtl/bcd_digit_to_xs3.sv
// Combinational single-digit BCD to Excess-3 converter; with CHK_EN, digits
// above 9 are flagged and forced to the invalid code.
module bcd_digit_to_xs3
    import excess3_pkg::*;
#(
    parameter bit CHK_EN = 1'b0
) (
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_code,
    output logic               o_invalid
);
    assign o_invalid = CHK_EN && (i_digit > BCD_MAX);
    assign o_code    = o_invalid ? XS3_INVALID : (i_digit + XS3_OFFSET);
endmodule

// File: rtl/excess3_seq_ctrl.sv
// Converts a packed NDIG-digit BCD word to Excess-3, one digit per clock, through
// one shared digit converter. Define EXCESS3_INVALID_CHK_EN to flag digits above 9.
module excess3_seq_ctrl
    import excess3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    excess3_seq_ctrl_if.slave  bus
);
`ifdef EXCESS3_INVALID_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam int               IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t                          r_state;
    logic [IDX_W-1:0]                r_idx;
    logic [NDIG-1:0][DIGIT_W-1:0]    r_word;
    logic [NDIG-1:0][DIGIT_W-1:0]    r_xs3;
    logic                            r_err;

    logic [DIGIT_W-1:0]              w_digit;
    logic [DIGIT_W-1:0]              w_code;
    logic                            w_inv;

    // r_idx never exceeds LAST_IDX, so the mux stays within the word.
    assign w_digit = r_word[r_idx];

    bcd_digit_to_xs3 #(.CHK_EN(CHK_EN)) u_conv (
        .i_digit   (w_digit),
        .o_code    (w_code),
        .o_invalid (w_inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_word  <= '0;
            r_xs3   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_word  <= bus.in_bcd;
                    r_idx   <= '0;
                    r_xs3   <= '0;
                    r_err   <= 1'b0;
                    r_state <= CONV;
                end
                CONV: begin
                    r_xs3[r_idx] <= w_code;
                    r_err        <= r_err | w_inv;
                    if (r_idx == LAST_IDX) r_state <= DONE;
                    else                   r_idx   <= r_idx + 1'b1;
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_xs3   = r_xs3;
    assign bus.out_err   = r_err;
endmodule

// File: tb/tb_excess3_seq_ctrl.sv
// Directed table-driven bench for excess3_seq_ctrl (NDIG=4) plus hand-written
// backpressure, back-to-back and mid-operation reset sequences.
module tb_excess3_seq_ctrl;
    localparam int NDIG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    excess3_seq_ctrl_if #(.NDIG(NDIG)) bus();

    excess3_seq_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] xs3;
        logic        err;
    } vec_t;

    vec_t vecs[6];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for out_valid; returns the number of edges taken.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    // Accept one word with out_ready high, check latency, result and return to IDLE.
    task automatic run_word(input string name, input logic [15:0] bcd,
                            input logic [15:0] exp_xs3, input logic exp_err);
        int cnt;
        @(negedge clk);
        chk({name, "_in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_bcd   = bcd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(cnt);
        chk({name, "_latency"}, cnt, NDIG);
        chk({name, "_xs3"}, bus.out_xs3, exp_xs3);
        chk({name, "_err"}, bus.out_err, exp_err);
        @(posedge clk); #1;
        chk({name, "_idle"}, {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{16'h1234, 16'h4567, 1'b0};
        vecs[1] = '{16'h0000, 16'h3333, 1'b0};
        vecs[2] = '{16'h9999, 16'hCCCC, 1'b0};
        vecs[3] = '{16'h0509, 16'h383C, 1'b0};
`ifdef EXCESS3_INVALID_CHK_EN
        vecs[4] = '{16'h12A4, 16'h45F7, 1'b1};
`else
        vecs[4] = '{16'h12A4, 16'h45D7, 1'b0};
`endif
        vecs[5] = '{16'h0001, 16'h3334, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_xs3", bus.out_xs3, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_word($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].xs3, vecs[i].err);

        // Backpressure: result held 6 cycles, in_valid ignored while DONE
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_bcd    = 16'h0509;
        @(posedge clk); #1;
        bus.in_bcd = 16'h7777;
        wait_valid(cnt);
        chk("bp_latency", cnt, NDIG);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", k),
                {bus.out_valid, bus.in_ready, bus.out_xs3}, {1'b1, 1'b0, 16'h383C});
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);

        // Back-to-back: in_valid held high, second word taken on first IDLE cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h2468;
        @(posedge clk); #1;
        bus.in_bcd = 16'h1357;
        wait_valid(cnt);
        chk("b2b_a_xs3", bus.out_xs3, 16'h579B);
        @(posedge clk); #1;
        chk("b2b_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        chk("b2b_b_accept", bus.busy, 1);
        bus.in_valid = 1'b0;
        wait_valid(cnt);
        chk("b2b_b_latency", cnt, NDIG);
        chk("b2b_b_xs3", bus.out_xs3, 16'h468A);
        @(posedge clk); #1;

        // Mid-operation reset two edges after accept
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h8765;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_async", {bus.busy, bus.out_valid, bus.in_ready, bus.out_xs3},
            {1'b0, 1'b0, 1'b1, 16'h0000});
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_no_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_after_idle", {bus.busy, bus.out_valid}, 2'b00);
        run_word("post_rst", 16'h0001, 16'h3334, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
